// File: rtl/rvc_fetch_align.sv
// rvc_fetch_align: halfword realigner with RVC-to-RV32I expansion feeding IF/ID
module rvc_fetch_align #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_is_rvc,
  output logic        out_illegal,
  input  logic        flush,
  input  logic [31:0] flush_pc
);
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic [15:0] r_hb [4];
  logic [2:0]  r_cnt;
  logic [31:0] r_pc;
  logic        r_skip;
  logic [15:0] w_c, w_lo;
  logic [15:0] w_sh [4];
  logic [15:0] w_nhb [4];
  logic [4:0]  w_rd, w_rs2, w_rdp, w_rs1p;
  logic        w_is16, w_take, w_acc, w_ill;
  logic [2:0]  w_cons, w_base, w_add;
  logic [31:0] w_exp;
  assign w_c    = r_hb[0];
  assign w_rd   = w_c[11:7];
  assign w_rs2  = w_c[6:2];
  assign w_rdp  = {2'b01, w_c[4:2]};
  assign w_rs1p = {2'b01, w_c[9:7]};
  assign w_is16 = w_c[1:0] != 2'b11;
  assign out_valid = !flush && ((r_cnt >= 3'd1 && w_is16) || r_cnt >= 3'd2);
  assign in_ready  = r_cnt <= 3'd2 && !flush;
  assign w_take = out_valid && out_ready;
  assign w_acc  = in_valid && in_ready;
  assign w_cons = w_take ? (w_is16 ? 3'd1 : 3'd2) : 3'd0;
  assign w_base = r_cnt - w_cons;
  assign w_add  = w_acc ? (r_skip ? 3'd1 : 3'd2) : 3'd0;
  assign w_lo   = r_skip ? in_data[31:16] : in_data[15:0];
  assign out_pc      = r_pc;
  assign out_is_rvc  = out_valid && w_is16;
  assign out_illegal = out_valid && w_is16 && w_ill;
  assign out_instr   = !out_valid ? NOP : !w_is16 ? {r_hb[1], r_hb[0]} : w_ill ? NOP : w_exp;
  // shift out consumed halfwords, then append the accepted word behind what remains
  always_comb begin
    w_sh[0] = w_cons == 3'd2 ? r_hb[2] : w_cons == 3'd1 ? r_hb[1] : r_hb[0];
    w_sh[1] = w_cons == 3'd2 ? r_hb[3] : w_cons == 3'd1 ? r_hb[2] : r_hb[1];
    w_sh[2] = w_cons == 3'd1 ? r_hb[3] : r_hb[2];
    w_sh[3] = r_hb[3];
    for (int i = 0; i < 4; i++)
      w_nhb[i] = (w_acc && w_base == 3'(i)) ? w_lo :
                 (w_acc && !r_skip && 3'(w_base + 3'd1) == 3'(i)) ? in_data[31:16] : w_sh[i];
  end
  // buffer state; flush wins over any accept or consume in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hb   <= '{default: 16'h0};
      r_cnt  <= 3'd0;
      r_pc   <= RESET_PC;
      r_skip <= RESET_PC[1];
    end else if (flush) begin
      r_cnt  <= 3'd0;
      r_pc   <= {flush_pc[31:1], 1'b0};
      r_skip <= flush_pc[1];
    end else begin
      r_hb   <= w_nhb;
      r_cnt  <= w_base + w_add;
      r_pc   <= r_pc + (w_take ? (w_is16 ? 32'd2 : 32'd4) : 32'd0);
      r_skip <= r_skip && !w_acc;
    end
  end
  // expand the 16-bit instruction at hb[0] into its RV32I form
  always_comb begin
    w_exp = NOP;
    w_ill = 1'b0;
    case ({w_c[1:0], w_c[15:13]})
      5'b00_000: begin
        w_exp = {2'b00, w_c[10:7], w_c[12:11], w_c[5], w_c[6], 2'b00, 5'd2, 3'b000, w_rdp, 7'h13};
        w_ill = w_c[12:5] == 8'h0;
      end
      5'b00_010: w_exp = {5'b0, w_c[5], w_c[12:10], w_c[6], 2'b00, w_rs1p, 3'b010, w_rdp, 7'h03};
      5'b00_110: w_exp = {5'b0, w_c[5], w_c[12], w_rdp, w_rs1p, 3'b010, w_c[11:10], w_c[6], 2'b00, 7'h23};
      5'b01_000: w_exp = {{7{w_c[12]}}, w_c[6:2], w_rd, 3'b000, w_rd, 7'h13};
      5'b01_001, 5'b01_101:
        w_exp = {w_c[12], w_c[8], w_c[10:9], w_c[6], w_c[7], w_c[2], w_c[11], w_c[5:3],
                 w_c[12], {8{w_c[12]}}, 4'b0, ~w_c[15], 7'h6f};
      5'b01_010: w_exp = {{7{w_c[12]}}, w_c[6:2], 5'd0, 3'b000, w_rd, 7'h13};
      5'b01_011: begin
        w_exp = {{3{w_c[12]}}, w_c[4:3], w_c[5], w_c[2], w_c[6], 4'b0, 5'd2, 3'b000, 5'd2, 7'h13};
        w_ill = w_rd != 5'd2 || {w_c[12], w_c[6:2]} == 6'h0;
      end
      5'b01_100: begin
        w_exp = w_c[11:10] == 2'b00 ? {7'b0000000, w_c[6:2], w_rs1p, 3'b101, w_rs1p, 7'h13} :
                w_c[11:10] == 2'b01 ? {7'b0100000, w_c[6:2], w_rs1p, 3'b101, w_rs1p, 7'h13} :
                w_c[11:10] == 2'b10 ? {{7{w_c[12]}}, w_c[6:2], w_rs1p, 3'b111, w_rs1p, 7'h13} :
                {1'b0, w_c[6:5] == 2'b00, 5'b0, w_rdp, w_rs1p,
                 w_c[6:5] == 2'b00 ? 3'b000 : w_c[6:5] == 2'b01 ? 3'b100 : w_c[6:5] == 2'b10 ? 3'b110 : 3'b111,
                 w_rs1p, 7'h33};
        w_ill = w_c[11:10] != 2'b10 && w_c[12];
      end
      5'b01_110, 5'b01_111:
        w_exp = {w_c[12], {3{w_c[12]}}, w_c[6:5], w_c[2], 5'd0, w_rs1p, {2'b00, w_c[13]},
                 w_c[11:10], w_c[4:3], w_c[12], 7'h63};
      5'b10_000: begin
        w_exp = {7'b0, w_c[6:2], w_rd, 3'b001, w_rd, 7'h13};
        w_ill = w_c[12];
      end
      5'b10_010: begin
        w_exp = {4'b0, w_c[3:2], w_c[12], w_c[6:4], 2'b00, 5'd2, 3'b010, w_rd, 7'h03};
        w_ill = w_rd == 5'd0;
      end
      5'b10_100: begin
        w_exp = w_rs2 != 5'd0 ? {7'b0, w_rs2, w_c[12] ? w_rd : 5'd0, 3'b000, w_rd, 7'h33} :
                {12'b0, w_rd, 3'b000, 4'b0, w_c[12], 7'h67};
        w_ill = w_rs2 == 5'd0 && w_rd == 5'd0;
      end
      5'b10_110: w_exp = {4'b0, w_c[8:7], w_c[12], w_rs2, 5'd2, 3'b010, w_c[11:9], 2'b00, 7'h23};
      default: w_ill = 1'b1;
    endcase
  end
endmodule
